// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and buffer entry type for the instruction fetch unit.
package fetch_pkg;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ALIGN_MASK = INSTR_BYTES - 1;
    localparam int ENTRY_ADDR_W = 64;
    localparam int ENTRY_INSTR_W = 32;
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0]  address;
        logic [ENTRY_INSTR_W-1:0] instruction;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer with push, pop, synchronous flush and occupancy count.
module fetch_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic do_pop;
    assign do_pop = pop && count != '0;
    assign dout = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (do_pop) rptr <= rptr + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= din;
    end
    // Credit accounting upstream must keep this buffer from overflowing.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: in-order fetch with buffering, stall and redirect flush.
// Define FETCH_BYTE_SWAP_EN to byte-reverse each accepted memory word (little-endian image).
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int instructionWidth = 32,
    parameter int addressSize = 64,
    parameter logic [addressSize-1:0] resetVector = '0,
    parameter int fifoDepth = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        stall_i,
    input  logic                        redirect_i,
    input  logic [addressSize-1:0]      redirectAddress_i,
    output logic                        imemReq_o,
    output logic [addressSize-1:0]      imemAddr_o,
    input  logic                        imemGnt_i,
    input  logic                        imemRvalid_i,
    input  logic [instructionWidth-1:0] imemRdata_i,
    output logic [instructionWidth-1:0] instruction_o,
    output logic [addressSize-1:0]      instructionAddress_o,
    output logic                        enable_o
);
    localparam int CW = $clog2(fifoDepth) + 1;
    localparam logic [addressSize-1:0] ALIGN = ~addressSize'(ALIGN_MASK);
    logic [addressSize-1:0] pc, aq_head;
    logic [CW-1:0] outstanding, discard, fifo_count, aq_count;
    logic grant, accept, load;
    logic [instructionWidth-1:0] rdata;
    fetch_entry_t push_entry, head_entry;
    // Credit covers both in-flight requests and buffered words so the buffer never overflows.
    assign imemReq_o = reset_i && enable_i && !redirect_i && (outstanding + fifo_count < CW'(fifoDepth));
    assign imemAddr_o = pc;
    assign grant = imemReq_o && imemGnt_i;
    assign accept = imemRvalid_i && !redirect_i && discard == '0;
    assign load = fifo_count != '0 && (!enable_o || !stall_i);
`ifdef FETCH_BYTE_SWAP_EN
    assign rdata = {<<8{imemRdata_i}};
`else
    assign rdata = imemRdata_i;
`endif
    assign push_entry = '{address: ENTRY_ADDR_W'(aq_head), instruction: ENTRY_INSTR_W'(rdata)};
    fetch_fifo #(.W(addressSize), .DEPTH(fifoDepth)) addr_q (
        .clk(clock_i), .rst_n(reset_i), .flush(redirect_i),
        .push(grant), .din(pc), .pop(accept), .dout(aq_head), .count(aq_count)
    );
    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(fifoDepth)) data_q (
        .clk(clock_i), .rst_n(reset_i), .flush(redirect_i),
        .push(accept), .din(push_entry), .pop(load), .dout(head_entry), .count(fifo_count)
    );
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pc <= resetVector & ALIGN;
            outstanding <= '0;
            discard <= '0;
        end else begin
            pc <= redirect_i ? redirectAddress_i & ALIGN : grant ? pc + addressSize'(INSTR_BYTES) : pc;
            outstanding <= outstanding + CW'(grant) - CW'(imemRvalid_i);
            // Requests still in flight at a redirect return stale words that must be dropped.
            discard <= redirect_i ? outstanding - CW'(imemRvalid_i)
                     : (imemRvalid_i && discard != '0) ? discard - CW'(1) : discard;
        end
    end
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            enable_o <= 1'b0;
            instruction_o <= '0;
            instructionAddress_o <= '0;
        end else if (redirect_i) begin
            enable_o <= 1'b0;
        end else if (load) begin
            enable_o <= 1'b1;
            instruction_o <= instructionWidth'(head_entry.instruction);
            instructionAddress_o <= addressSize'(head_entry.address);
        end else if (!stall_i) begin
            enable_o <= 1'b0;
        end
    end
    assert property (@(posedge clock_i) disable iff (!reset_i) accept |-> aq_count != '0);
endmodule
